// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the CPU/device memory arbiter: read-owner tags and
// starvation FSM states.
package mem_arbiter_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DEV  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_reg.sv
// Enabled data register with synchronous active-high reset; holds the last
// word returned to the CPU.
module mem_arbiter_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        data_d = en ? d : data_q;
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU has fixed priority, the loader/DMA port is
// granted on idle cycles, and a starvation FSM freezes the CPU for one cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_re,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic              dev_ack,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              dev_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_e            state_d, state_q;
    owner_e            owner_d, owner_q;
    logic [CNT_W-1:0]  starve_cnt_d, starve_cnt_q;
    logic [CNT_W-1:0]  starve_inc;
    logic              cpu_hold_d, cpu_hold_q;
    logic              cpu_access, dev_grant;
    logic              cpu_rdata_en;
    logic [DATA_W-1:0] cpu_rdata_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cpu_access = (cpu_re | cpu_we) & ~cpu_hold_q;
        dev_grant  = dev_req & ~cpu_access;

        ram_addr  = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        owner_d   = OWN_NONE;
        if (cpu_access) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
            ram_re    = cpu_re & ~cpu_we;
            if (cpu_re && !cpu_we) owner_d = OWN_CPU;
        end else if (dev_grant) begin
            ram_addr  = dev_addr;
            ram_wdata = dev_wdata;
            ram_we    = dev_we;
            ram_re    = ~dev_we;
            if (!dev_we) owner_d = OWN_DEV;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        starve_inc   = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (dev_req && !dev_grant) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dev_grant || !dev_req) begin
                    state_d      = ST_IDLE;
                    starve_cnt_d = '0;
                end else if (starve_inc == LIMIT) begin
                    state_d      = ST_HOLD;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = starve_inc;
                end
            end
            // The CPU is frozen here, so dev is either granted or has dropped.
            ST_HOLD: state_d = ST_IDLE;
            default: begin
                state_d      = ST_IDLE;
                starve_cnt_d = '0;
            end
        endcase
        cpu_hold_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            owner_q      <= OWN_NONE;
            cpu_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    assign cpu_rdata_en = (owner_q == OWN_CPU);

    mem_arbiter_reg #(.WIDTH(DATA_W)) u_cpu_rdata (
        .clk   (clk),
        .reset (reset),
        .en    (cpu_rdata_en),
        .d     (ram_rdata),
        .q     (cpu_rdata_q)
    );

    assign cpu_rdata  = cpu_rdata_en ? ram_rdata : cpu_rdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign dev_ack    = dev_grant;
    assign dev_rdata  = ram_rdata;
    assign dev_rvalid = (owner_q == OWN_DEV);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a cycle-level reference model and a behavioural RAM.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] cpu_addr, dev_addr, ram_addr;
    logic [31:0] cpu_wdata, dev_wdata, ram_wdata, cpu_rdata, dev_rdata;
    logic [31:0] ram_rdata = '0;
    logic        cpu_re, cpu_we, cpu_hold, dev_req, dev_we, dev_ack, dev_rvalid, ram_re, ram_we;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_ack(dev_ack), .dev_rdata(dev_rdata), .dev_rvalid(dev_rvalid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    // Behavioural RAM (driven by the DUT's actual ram_* outputs).
    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Reference model: streak of consecutive refused dev requests, one-cycle hold
    // once the streak exceeds the limit, and pending-read bookkeeping.
    bit          m_hold, m_cpu_pend, m_dev_pend, m_cpu_acc, m_grant;
    int          m_streak;
    logic [31:0] m_cpu_last;

    logic [29:0] exp_ram_addr;
    logic [31:0] exp_ram_wdata, exp_cpu_rdata;
    logic        exp_ram_re, exp_ram_we, exp_dev_ack, exp_cpu_hold, exp_dev_rvalid;

    int vectors = 0;
    int miscompares = 0;

    task automatic apply(input bit rst, input bit cre, input bit cwe, input logic [29:0] ca,
                         input logic [31:0] cw, input bit dr, input bit dwe,
                         input logic [29:0] da, input logic [31:0] dw);
        reset = rst; cpu_re = cre; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
        dev_req = dr; dev_we = dwe; dev_addr = da; dev_wdata = dw;
        #1;
        m_cpu_acc = (cre || cwe) && !m_hold;
        m_grant   = dr && !m_cpu_acc;
        exp_ram_addr = '0; exp_ram_wdata = '0; exp_ram_re = 1'b0; exp_ram_we = 1'b0;
        if (m_cpu_acc) begin
            exp_ram_addr = ca; exp_ram_wdata = cw; exp_ram_we = cwe; exp_ram_re = cre && !cwe;
        end else if (m_grant) begin
            exp_ram_addr = da; exp_ram_wdata = dw; exp_ram_we = dwe; exp_ram_re = !dwe;
        end
        exp_dev_ack    = m_grant;
        exp_cpu_hold   = m_hold;
        exp_dev_rvalid = m_dev_pend;
        exp_cpu_rdata  = m_cpu_pend ? ram_rdata : m_cpu_last;
    endtask

    task automatic tick();
        logic [31:0] nxt_rdata;
        bit          do_wr;
        logic [29:0] wr_a;
        logic [31:0] wr_d;
        nxt_rdata = ram_rdata;
        do_wr = ram_we; wr_a = ram_addr; wr_d = ram_wdata;
        if (ram_re) nxt_rdata = mem_rd(ram_addr);
        if (reset) begin
            m_hold = 0; m_streak = 0; m_cpu_pend = 0; m_dev_pend = 0; m_cpu_last = '0;
        end else begin
            if (m_cpu_pend) m_cpu_last = ram_rdata;
            m_cpu_pend = m_cpu_acc && cpu_re && !cpu_we;
            m_dev_pend = m_grant && !dev_we;
            if (dev_req && !m_grant) m_streak++;
            else                     m_streak = 0;
            m_hold = (m_streak == LIMIT + 1);
            if (m_hold) m_streak = 0;
        end
        @(posedge clk);
        @(negedge clk);
        if (do_wr) mem[wr_a] = wr_d;
        ram_rdata = nxt_rdata;
    endtask

    task automatic idle();
        apply(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        apply(1, 0, 0, '0, '0, 0, 0, '0, '0); tick();
        apply(1, 0, 0, '0, '0, 0, 0, '0, '0); tick();
        idle();
        vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL reset_hold: got %b want 0", cpu_hold); end
        vectors++; if (dev_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b want 0", dev_rvalid); end
        vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        vectors++; if (dut.starve_cnt_q !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", dut.starve_cnt_q); end
        tick();
    endtask

    task automatic test_cpu_read();
        mem[30'h10] = 32'hCAFE_0010;
        apply(0, 1, 0, 30'h10, 32'h55, 0, 0, '0, '0);
        vectors++; if (ram_re !== 1'b1) begin miscompares++; $display("FAIL cpu_rd_re: got %b want 1", ram_re); end
        vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL cpu_rd_we: got %b want 0", ram_we); end
        vectors++; if (ram_addr !== 30'h10) begin miscompares++; $display("FAIL cpu_rd_addr: got %h want 10", ram_addr); end
        vectors++; if (dev_ack !== 1'b0) begin miscompares++; $display("FAIL cpu_rd_ack: got %b want 0", dev_ack); end
        tick();
        idle();
        vectors++; if (cpu_rdata !== 32'hCAFE_0010) begin miscompares++; $display("FAIL cpu_rd_data: got %h want cafe0010", cpu_rdata); end
        tick();
        idle();
        vectors++; if (cpu_rdata !== 32'hCAFE_0010) begin miscompares++; $display("FAIL cpu_rd_keep: got %h want cafe0010", cpu_rdata); end
        tick();
    endtask

    task automatic test_dev_write();
        apply(0, 0, 0, '0, '0, 1, 1, 30'h20, 32'hDEAD_BEEF);
        vectors++; if (dev_ack !== 1'b1) begin miscompares++; $display("FAIL dev_wr_ack: got %b want 1", dev_ack); end
        vectors++; if (ram_we !== 1'b1 || ram_re !== 1'b0) begin miscompares++; $display("FAIL dev_wr_we_re: got %b%b want 10", ram_we, ram_re); end
        vectors++; if (ram_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL dev_wr_data: got %h want deadbeef", ram_wdata); end
        vectors++; if (ram_addr !== 30'h20) begin miscompares++; $display("FAIL dev_wr_addr: got %h want 20", ram_addr); end
        tick();
        apply(0, 0, 0, '0, '0, 1, 0, 30'h20, '0);
        vectors++; if (dev_ack !== 1'b1 || ram_re !== 1'b1) begin miscompares++; $display("FAIL dev_rd_grant: got ack=%b re=%b want 1 1", dev_ack, ram_re); end
        tick();
        idle();
        vectors++; if (dev_rvalid !== 1'b1) begin miscompares++; $display("FAIL dev_rd_valid: got %b want 1", dev_rvalid); end
        vectors++; if (dev_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL dev_rd_data: got %h want deadbeef", dev_rdata); end
        tick();
        idle();
        vectors++; if (dev_rvalid !== 1'b0) begin miscompares++; $display("FAIL dev_rd_once: got %b want 0", dev_rvalid); end
        tick();
    endtask

    // CPU reads 0x10 every cycle while dev wants 0x20: one refused IDLE cycle,
    // LIMIT refused WAIT cycles, then a HOLD cycle where dev wins.
    task automatic test_starvation();
        for (int i = 0; i <= LIMIT + 1; i++) begin
            apply(0, 1, 0, 30'h10, '0, 1, 0, 30'h20, '0);
            if (i <= LIMIT) begin
                vectors++; if (cpu_hold !== 1'b0 || dev_ack !== 1'b0) begin miscompares++; $display("FAIL starve_wait[%0d]: got hold=%b ack=%b want 0 0", i, cpu_hold, dev_ack); end
                vectors++; if (ram_addr !== 30'h10) begin miscompares++; $display("FAIL starve_cpu_addr[%0d]: got %h want 10", i, ram_addr); end
            end else begin
                vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL starve_hold: got %b want 1", cpu_hold); end
                vectors++; if (dev_ack !== 1'b1) begin miscompares++; $display("FAIL starve_ack: got %b want 1", dev_ack); end
                vectors++; if (ram_addr !== 30'h20 || ram_re !== 1'b1) begin miscompares++; $display("FAIL starve_dev_access: got addr=%h re=%b want 20 1", ram_addr, ram_re); end
            end
            tick();
        end
        idle();
        vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL hold_release: got %b want 0", cpu_hold); end
        vectors++; if (dev_rvalid !== 1'b1 || dev_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL hold_dev_read: got v=%b d=%h want 1 deadbeef", dev_rvalid, dev_rdata); end
        vectors++; if (cpu_rdata !== 32'hCAFE_0010) begin miscompares++; $display("FAIL hold_cpu_keep: got %h want cafe0010", cpu_rdata); end
        tick();
    endtask

    task automatic test_write_priority_and_drop();
        apply(0, 1, 1, 30'h30, 32'h1234_5678, 0, 0, '0, '0);
        vectors++; if (ram_we !== 1'b1 || ram_re !== 1'b0) begin miscompares++; $display("FAIL cpu_rw_both: got we=%b re=%b want 1 0", ram_we, ram_re); end
        vectors++; if (ram_wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL cpu_rw_data: got %h want 12345678", ram_wdata); end
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 30'h30, '0, 1, 0, 30'h20, '0);
            tick();
        end
        vectors++; if (dut.state_q !== ST_WAIT || dut.starve_cnt_q !== 8'd2) begin miscompares++; $display("FAIL wait_count: got st=%0d cnt=%0d want WAIT 2", dut.state_q, dut.starve_cnt_q); end
        apply(0, 1, 0, 30'h30, '0, 0, 0, '0, '0);
        tick();
        idle();
        vectors++; if (dut.state_q !== ST_IDLE || dut.starve_cnt_q !== 8'd0) begin miscompares++; $display("FAIL drop_to_idle: got st=%0d cnt=%0d want IDLE 0", dut.state_q, dut.starve_cnt_q); end
        tick();
    endtask

    task automatic test_withdraw();
        apply(0, 0, 0, '0, '0, 0, 1, 30'h3, 32'hFFFF_0000);
        vectors++; if (dev_ack !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin miscompares++; $display("FAIL withdraw_access: got ack=%b we=%b re=%b want 0 0 0", dev_ack, ram_we, ram_re); end
        vectors++; if (ram_addr !== '0 || ram_wdata !== '0) begin miscompares++; $display("FAIL withdraw_bus: got a=%h d=%h want 0 0", ram_addr, ram_wdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) mem[30'h40 + 30'(i)] = 32'hB0B0_0000 + 32'(i);
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) apply(0, 0, 0, '0, '0, 1, 0, 30'h40 + 30'(i), '0);
            else       idle();
            if (i < 5) begin
                vectors++; if (dev_ack !== 1'b1 || ram_addr !== 30'h40 + 30'(i)) begin miscompares++; $display("FAIL b2b_grant[%0d]: got ack=%b a=%h want 1 %h", i, dev_ack, ram_addr, 30'h40 + 30'(i)); end
            end
            if (i > 0) begin
                vectors++; if (dev_rvalid !== 1'b1 || dev_rdata !== 32'hB0B0_0000 + 32'(i - 1)) begin miscompares++; $display("FAIL b2b_data[%0d]: got v=%b d=%h want 1 %h", i, dev_rvalid, dev_rdata, 32'hB0B0_0000 + 32'(i - 1)); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        apply(1, 0, 0, '0, '0, 1, 0, 30'h40, '0);
        vectors++; if (dev_ack !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ack: got %b want 1", dev_ack); end
        tick();
        idle();
        vectors++; if (dev_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_rvalid: got %b want 0", dev_rvalid); end
        vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL rst_mid_state: got %0d want IDLE", dut.state_q); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            apply($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom), 30'($urandom_range(0, 15)),
                  $urandom, $urandom_range(0, 9) < 7, 1'($urandom), 30'($urandom_range(0, 15)), $urandom);
            vectors++;
            if (ram_re !== exp_ram_re || ram_we !== exp_ram_we || ram_addr !== exp_ram_addr || ram_wdata !== exp_ram_wdata) begin
                miscompares++; $display("FAIL rnd_ram[%0d]: got re=%b we=%b a=%h d=%h want re=%b we=%b a=%h d=%h", n, ram_re, ram_we, ram_addr, ram_wdata, exp_ram_re, exp_ram_we, exp_ram_addr, exp_ram_wdata);
            end
            vectors++;
            if (dev_ack !== exp_dev_ack || cpu_hold !== exp_cpu_hold || dev_rvalid !== exp_dev_rvalid) begin
                miscompares++; $display("FAIL rnd_ctrl[%0d]: got ack=%b hold=%b rv=%b want %b %b %b", n, dev_ack, cpu_hold, dev_rvalid, exp_dev_ack, exp_cpu_hold, exp_dev_rvalid);
            end
            vectors++;
            if (cpu_rdata !== exp_cpu_rdata) begin
                miscompares++; $display("FAIL rnd_cpu_rdata[%0d]: got %h want %h", n, cpu_rdata, exp_cpu_rdata);
            end
            if (exp_dev_rvalid) begin
                vectors++;
                if (dev_rdata !== ram_rdata) begin miscompares++; $display("FAIL rnd_dev_rdata[%0d]: got %h want %h", n, dev_rdata, ram_rdata); end
            end
            tick();
        end
    endtask

    initial begin
        m_hold = 0; m_streak = 0; m_cpu_pend = 0; m_dev_pend = 0; m_cpu_last = '0;
        for (int i = 0; i < 16; i++) mem[30'(i)] = $urandom;
        @(negedge clk);
        test_reset();
        test_cpu_read();
        test_dev_write();
        test_starvation();
        test_write_priority_and_drop();
        test_withdraw();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
